// File: rtl/mmio_uart_pkg.sv
// Shared register map, STATUS/CONTROL bit positions and TX FSM encoding.
package mmio_uart_pkg;

  localparam int unsigned LANES = 4;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_TXWORD = 2'd1;
  localparam logic [1:0] OFF_RXDATA = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int unsigned ST_TX_FULL      = 0;
  localparam int unsigned ST_TX_EMPTY     = 1;
  localparam int unsigned ST_RX_EMPTY     = 2;
  localparam int unsigned ST_RX_FULL      = 3;
  localparam int unsigned ST_RX_OVERRUN   = 4;
  localparam int unsigned ST_TX_OVERFLOW  = 5;
  localparam int unsigned ST_TX_BUSY      = 6;
  localparam int unsigned ST_RX_COUNT_LSB = 8;
  localparam int unsigned ST_TX_COUNT_LSB = 16;

  localparam int unsigned CTL_RX_FLUSH = 0;
  localparam int unsigned CTL_TX_FLUSH = 1;
  localparam int unsigned CTL_IRQ_EN   = 2;
  localparam int unsigned CTL_SEL      = 31;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_LOAD  = 2'd1,
    TX_START = 2'd2,
    TX_WAIT  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a multi-lane push (0..LANES entries per cycle) and flush.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LANES = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2:0]               push_count,
  input  logic [LANES*WIDTH-1:0]   din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             pop_ok;

  // A pop on an empty FIFO is ignored; the caller has already checked space for pushes.
  assign pop_ok = pop & (cnt != '0);
  assign dout   = mem[rd_ptr];
  assign count  = cnt;
  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);

  // Storage: write up to LANES consecutive entries starting at wr_ptr.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!flush && (3'(i) < push_count)) begin
        mem[wr_ptr + AW'(i)] <= din[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pointers and occupancy; flush overrides any same-cycle push or pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_count);
      rd_ptr <= rd_ptr + AW'(pop_ok);
      cnt    <= cnt + CW'(push_count) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/mmio_uart_bridge.sv
// MMIO front end buffering UART TX/RX bytes, with word-send, sticky errors and RX irq.
module mmio_uart_bridge
  import mmio_uart_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] in_address,
  input  logic [31:0] in_write_data,
  input  logic        in_write_en,
  input  logic        in_read_en,
  output logic [31:0] out_read_data,
  output logic [7:0]  out_tx_byte,
  output logic        out_tx_start,
  input  logic        in_tx_active,
  input  logic        in_tx_done,
  input  logic [7:0]  in_rx_byte,
  input  logic        in_rx_valid,
  output logic        out_irq
);

  localparam int unsigned TCW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RCW = $clog2(RX_DEPTH) + 1;

  logic [1:0]     offset;
  logic           wr_txdata, wr_txword, wr_status, ctrl_wr, w1c;
  logic           rx_flush, tx_flush, irq_en;
  logic           rx_overrun, tx_overflow, rx_overrun_set, tx_overflow_set;
  logic [2:0]     tx_push_n;
  logic           tx_pop_c, tx_full, tx_empty;
  logic [7:0]     tx_head;
  logic [TCW-1:0] tx_count;
  logic           rx_pop, rx_pop_ok, rx_push, rx_full, rx_empty;
  logic [7:0]     rx_head;
  logic [RCW-1:0] rx_count;
  tx_state_e      state, state_next;
  logic           unused_addr;

  assign unused_addr = ^{in_address[11:4], in_address[1:0]};

  assign offset    = in_address[3:2];
  assign wr_txdata = in_write_en & (offset == OFF_TXDATA);
  assign wr_txword = in_write_en & (offset == OFF_TXWORD);
  assign wr_status = in_write_en & (offset == OFF_STATUS);
  assign ctrl_wr   = wr_status & in_write_data[CTL_SEL];
  assign w1c       = wr_status & ~in_write_data[CTL_SEL];
  assign rx_flush  = ctrl_wr & in_write_data[CTL_RX_FLUSH];
  assign tx_flush  = ctrl_wr & in_write_data[CTL_TX_FLUSH];

  // TX admission: single byte may use a same-cycle pop slot; a word needs 4 free entries.
  always_comb begin
    tx_push_n       = 3'd0;
    tx_overflow_set = 1'b0;
    if (wr_txdata) begin
      if (!tx_full || tx_pop_c) tx_push_n = 3'd1;
      else                      tx_overflow_set = 1'b1;
    end
    if (wr_txword) begin
      if (tx_count <= TCW'(TX_DEPTH - 4)) tx_push_n = 3'd4;
      else                                tx_overflow_set = 1'b1;
    end
  end

  // RX admission: a full FIFO still accepts when a pop frees a slot this cycle.
  assign rx_pop         = in_read_en & (offset == OFF_RXDATA);
  assign rx_pop_ok      = rx_pop & ~rx_empty;
  assign rx_push        = in_rx_valid & (~rx_full | rx_pop_ok);
  assign rx_overrun_set = in_rx_valid & rx_full & ~rx_pop_ok;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH), .LANES(LANES)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push_count(tx_push_n), .din(in_write_data),
    .pop(tx_pop_c), .flush(tx_flush), .dout(tx_head), .count(tx_count),
    .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH), .LANES(LANES)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push_count({2'b00, rx_push}), .din({24'd0, in_rx_byte}),
    .pop(rx_pop), .flush(rx_flush), .dout(rx_head), .count(rx_count),
    .full(rx_full), .empty(rx_empty)
  );

  // Sticky error flags (a new error beats a same-cycle clear), irq enable and irq output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
      irq_en      <= 1'b0;
      out_irq     <= 1'b0;
    end else begin
      rx_overrun  <= rx_overrun_set  | (rx_overrun  & ~(w1c & in_write_data[ST_RX_OVERRUN]));
      tx_overflow <= tx_overflow_set | (tx_overflow & ~(w1c & in_write_data[ST_TX_OVERFLOW]));
      if (ctrl_wr) irq_en <= in_write_data[CTL_IRQ_EN];
      out_irq     <= irq_en & ~rx_empty;
    end
  end

  // TX FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= TX_IDLE;
    else          state <= state_next;
  end

  // TX FSM next state; LOAD falls back to IDLE if a flush emptied the FIFO underneath it.
  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE:  if (!tx_empty && !in_tx_active) state_next = TX_LOAD;
      TX_LOAD:  state_next = tx_empty ? TX_IDLE : TX_START;
      TX_START: state_next = TX_WAIT;
      TX_WAIT:  if (in_tx_done) state_next = TX_IDLE;
      default:  state_next = TX_IDLE;
    endcase
  end

  // TX FSM outputs: pop the head in LOAD.
  always_comb begin
    tx_pop_c = 1'b0;
    if (state == TX_LOAD) tx_pop_c = ~tx_empty;
  end

  // Registered byte and one-cycle start pulse coinciding with the START state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_tx_byte  <= 8'd0;
      out_tx_start <= 1'b0;
    end else begin
      if (tx_pop_c) out_tx_byte <= tx_head;
      out_tx_start <= tx_pop_c;
    end
  end

  // Combinational read mux.
  always_comb begin
    out_read_data = 32'd0;
    case (offset)
      OFF_RXDATA: if (!rx_empty) out_read_data = {23'd0, 1'b1, rx_head};
      OFF_STATUS: begin
        out_read_data[ST_TX_FULL]     = tx_full;
        out_read_data[ST_TX_EMPTY]    = tx_empty;
        out_read_data[ST_RX_EMPTY]    = rx_empty;
        out_read_data[ST_RX_FULL]     = rx_full;
        out_read_data[ST_RX_OVERRUN]  = rx_overrun;
        out_read_data[ST_TX_OVERFLOW] = tx_overflow;
        out_read_data[ST_TX_BUSY]     = (state != TX_IDLE);
        out_read_data[ST_RX_COUNT_LSB +: 8] = 8'(rx_count);
        out_read_data[ST_TX_COUNT_LSB +: 8] = 8'(tx_count);
      end
      default: out_read_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Directed + randomized bench for mmio_uart_bridge with a queue-based reference model.
module tb_mmio_uart_bridge;

  logic        clk;
  logic        reset_n;
  logic [11:0] in_address;
  logic [31:0] in_write_data;
  logic        in_write_en, in_read_en;
  logic [31:0] out_read_data;
  logic [7:0]  out_tx_byte;
  logic        out_tx_start;
  logic        in_tx_active, in_tx_done;
  logic [7:0]  in_rx_byte;
  logic        in_rx_valid;
  logic        out_irq;

  logic        hold_active, uart_busy, uart_done, uart_kill;
  int          uart_timer;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  rx_q[$];
  int          checks, errors;

  assign in_tx_active = hold_active | uart_busy;
  assign in_tx_done   = uart_done;

  mmio_uart_bridge #(.TX_DEPTH(4), .RX_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_address(in_address), .in_write_data(in_write_data),
    .in_write_en(in_write_en), .in_read_en(in_read_en), .out_read_data(out_read_data),
    .out_tx_byte(out_tx_byte), .out_tx_start(out_tx_start), .in_tx_active(in_tx_active),
    .in_tx_done(in_tx_done), .in_rx_byte(in_rx_byte), .in_rx_valid(in_rx_valid),
    .out_irq(out_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART model: record each start, stay busy 10 cycles, then pulse done.
  always @(negedge clk) begin
    uart_done = 1'b0;
    if (uart_kill) begin
      uart_busy  = 1'b0;
      uart_timer = 0;
    end else if (out_tx_start) begin
      got_q.push_back(out_tx_byte);
      uart_busy  = 1'b1;
      uart_timer = 10;
    end else if (uart_timer > 0) begin
      uart_timer = uart_timer - 1;
      if (uart_timer == 0) begin
        uart_done = 1'b1;
        uart_busy = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] data);
    in_address    = {8'd0, off, 2'd0};
    in_write_data = data;
    in_write_en   = 1'b1;
    @(negedge clk);
    in_write_en   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] off, input logic pop, output logic [31:0] v);
    in_address = {8'd0, off, 2'd0};
    in_read_en = pop;
    #1 v = out_read_data;
    @(negedge clk);
    in_read_en = 1'b0;
  endtask

  task automatic peek_status(output logic [31:0] v);
    in_address = 12'hC;
    #1 v = out_read_data;
  endtask

  task automatic rx_push(input logic [7:0] b);
    in_rx_byte  = b;
    in_rx_valid = 1'b1;
    @(negedge clk);
    in_rx_valid = 1'b0;
  endtask

  // Wait until every expected byte has been started and the TX side is idle, then compare.
  task automatic tx_drain(input string tag);
    logic [31:0] s;
    int n;
    for (n = 0; n < 2000; n++) begin
      peek_status(s);
      if (got_q.size() == exp_tx.size() && !s[6] && s[1]) break;
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(n < 2000), 32'd1);
    check({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_tx[i]));
    got_q.delete();
    exp_tx.delete();
    @(negedge clk);
  endtask

  // Pop every byte in the RX model and expect it back, then an empty read.
  task automatic rx_drain(input string tag);
    logic [31:0] v;
    while (rx_q.size() > 0) begin
      rd(2'd2, 1'b1, v);
      check({tag, "_rd"}, v, {23'd0, 1'b1, rx_q.pop_front()});
    end
    rd(2'd2, 1'b1, v);
    check({tag, "_empty"}, v, 32'd0);
  endtask

  initial begin
    logic [31:0] s, v, w;
    logic [7:0]  b;
    int n;
    checks = 0; errors = 0;
    reset_n = 1'b0; in_address = 12'hC; in_write_data = '0; in_write_en = 1'b0;
    in_read_en = 1'b0; in_rx_byte = '0; in_rx_valid = 1'b0;
    hold_active = 1'b0; uart_busy = 1'b0; uart_done = 1'b0; uart_kill = 1'b0; uart_timer = 0;

    // Reset state
    #12;
    check("rst_start", 32'(out_tx_start), 32'd0);
    check("rst_byte", 32'(out_tx_byte), 32'd0);
    check("rst_irq", 32'(out_irq), 32'd0);
    check("rst_status", out_read_data, 32'h0000_0006);
    @(negedge clk); reset_n = 1'b1; @(negedge clk);

    // Two TXDATA bytes with start latency
    wr(2'd0, 32'hFFFF_FF41); exp_tx.push_back(8'h41);
    check("lat_c1", 32'(out_tx_start), 32'd0);
    @(negedge clk);
    check("lat_c2", 32'(out_tx_start), 32'd0);
    @(negedge clk);
    check("lat_start", 32'(out_tx_start), 32'd1);
    check("lat_byte", 32'(out_tx_byte), 32'h41);
    wr(2'd0, 32'h0000_0042); exp_tx.push_back(8'h42);
    tx_drain("txdata");
    peek_status(s);
    check("txdata_busy", 32'(s[6]), 32'd0);

    // TXWORD fixed and random, plus random TXDATA bursts
    wr(2'd1, 32'h4433_2211);
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22); exp_tx.push_back(8'h33); exp_tx.push_back(8'h44);
    tx_drain("txword");
    for (int r = 0; r < 3; r++) begin
      w = $urandom;
      wr(2'd1, w);
      for (int k = 0; k < 4; k++) exp_tx.push_back(w[8*k +: 8]);
      tx_drain("txword_rnd");
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        wr(2'd0, {24'($urandom), b});
        exp_tx.push_back(b);
      end
      tx_drain("txdata_rnd");
    end

    // Overflow: UART held busy, one byte queued, TXWORD rejected; then fill and overflow TXDATA
    hold_active = 1'b1;
    wr(2'd0, 32'h77); exp_tx.push_back(8'h77);
    wr(2'd1, $urandom);
    peek_status(s);
    check("txword_ovf_flag", 32'(s[5]), 32'd1);
    check("txword_ovf_cnt", 32'(s[23:16]), 32'd1);
    @(negedge clk);
    wr(2'd3, 32'h20);
    peek_status(s);
    check("ovf_w1c", 32'(s[5]), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      wr(2'd0, {24'd0, b});
      exp_tx.push_back(b);
    end
    wr(2'd0, 32'hEE);
    peek_status(s);
    check("txfull_flag", 32'(s[0]), 32'd1);
    check("txfull_ovf", 32'(s[5]), 32'd1);
    check("txfull_cnt", 32'(s[23:16]), 32'd4);
    @(negedge clk);
    hold_active = 1'b0;
    tx_drain("ovf_drain");
    wr(2'd3, 32'h20);

    // RX with interrupt
    wr(2'd3, 32'h8000_0004);
    rx_push(8'h5A); rx_q.push_back(8'h5A);
    check("irq_lag", 32'(out_irq), 32'd0);
    @(negedge clk);
    check("irq_rise", 32'(out_irq), 32'd1);
    rx_push(8'hA5); rx_q.push_back(8'hA5);
    rd(2'd2, 1'b1, v); check("rx_5a", v, 32'h15A); void'(rx_q.pop_front());
    rd(2'd2, 1'b1, v); check("rx_a5", v, 32'h1A5); void'(rx_q.pop_front());
    check("irq_hold", 32'(out_irq), 32'd1);
    rd(2'd2, 1'b1, v); check("rx_empty", v, 32'd0);
    check("irq_fall", 32'(out_irq), 32'd0);
    peek_status(s);
    check("rx_no_underflow", s & 32'h0000_FF14, 32'h0000_0004);
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 2);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        rx_push(b); rx_q.push_back(b);
      end
      peek_status(s);
      check("rx_rnd_cnt", 32'(s[15:8]), 32'(n));
      @(negedge clk);
      rx_drain("rx_rnd");
    end

    // RX overrun, W1C and simultaneous push/pop on full
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      rx_push(b);
      if (k < 2) rx_q.push_back(b);
    end
    peek_status(s);
    check("ovr_flag", 32'(s[4]), 32'd1);
    check("ovr_full", 32'(s[3]), 32'd1);
    check("ovr_cnt", 32'(s[15:8]), 32'd2);
    @(negedge clk);
    wr(2'd3, 32'h10);
    peek_status(s);
    check("ovr_w1c", 32'(s[4]), 32'd0);
    @(negedge clk);
    b = 8'($urandom);
    in_rx_byte = b; in_rx_valid = 1'b1;
    rd(2'd2, 1'b1, v);
    in_rx_valid = 1'b0;
    check("pushpop_rd", v, {23'd0, 1'b1, rx_q.pop_front()});
    rx_q.push_back(b);
    peek_status(s);
    check("pushpop_cnt", 32'(s[15:8]), 32'd2);
    check("pushpop_ovr", 32'(s[4]), 32'd0);
    @(negedge clk);
    rx_drain("pushpop");

    // Flush both FIFOs while a TX byte is in flight
    b = 8'($urandom);
    wr(2'd0, {24'd0, b}); exp_tx.push_back(b);
    wr(2'd0, 32'h0B); wr(2'd0, 32'h0C);
    for (n = 0; n < 50 && got_q.size() < 1; n++) @(negedge clk);
    check("flush_started", 32'(got_q.size()), 32'd1);
    rx_push(8'h99); rx_push(8'h98);
    wr(2'd3, 32'h8000_0003);
    peek_status(s);
    check("flush_counts", s & 32'h00FF_FF06, 32'h0000_0006);
    @(negedge clk);
    tx_drain("flush_inflight");
    for (int k = 0; k < 30; k++) @(negedge clk);
    check("flush_no_more", 32'(got_q.size()), 32'd0);

    // Asynchronous reset during WAIT
    b = 8'($urandom);
    wr(2'd0, {24'd0, b});
    for (n = 0; n < 50 && got_q.size() < 1; n++) @(negedge clk);
    check("rstw_started", 32'(got_q.size()), 32'd1);
    @(negedge clk); @(negedge clk);
    peek_status(s);
    check("rstw_busy_before", 32'(s[6]), 32'd1);
    #2 reset_n = 1'b0; uart_kill = 1'b1;
    #1;
    check("rstw_start", 32'(out_tx_start), 32'd0);
    check("rstw_status", out_read_data, 32'h0000_0006);
    check("rstw_byte", 32'(out_tx_byte), 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    uart_kill = 1'b0;
    for (int k = 0; k < 40; k++) @(negedge clk);
    check("rstw_no_resend", 32'(got_q.size()), 32'd1);
    peek_status(s);
    check("rstw_idle", s, 32'h0000_0006);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_bridge.md
Name: mmio_uart_bridge

Overview:
- MMIO peripheral between mmio_mapper and uart_controller.
- Buffers TX and RX bytes in parametrised FIFOs and adds a word-send mode that serialises a 32-bit write as 4 bytes, LSB first.
- Provides sticky error flags, flush controls and an RX interrupt.
- Replaces the direct byte pass-through, so the CPU no longer has to poll the UART for every byte.

Parameters:
- TX_DEPTH, 16, TX FIFO entries; power of two, 4..128.
- RX_DEPTH, 16, RX FIFO entries; power of two, 2..128.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_address  in  12  MMIO byte address; only [3:2] decoded
- in_write_data  in  32  MMIO write data
- in_write_en  in  1  one-cycle write strobe
- in_read_en  in  1  one-cycle read strobe; pops on RXDATA
- out_read_data  out  32  combinational read data for in_address
- out_tx_byte  out  8  byte presented to UART
- out_tx_start  out  1  one-cycle transmit request
- in_tx_active  in  1  UART transmitter busy
- in_tx_done  in  1  one-cycle UART byte-complete pulse
- in_rx_byte  in  8  received byte
- in_rx_valid  in  1  one-cycle received-byte pulse
- out_irq  out  1  RX interrupt

Behaviour:
- Reset (async, reset_n=0):
  - Both FIFOs are emptied and the sticky flags are cleared.
  - CONTROL is 0, the TX FSM is IDLE, out_tx_start=0, out_tx_byte=0 and out_irq=0.
  - Reset mid-frame abandons the byte in flight; nothing is retransmitted.
- Register map, by in_address[3:2]:
  - 0 TXDATA (W): pushes in_write_data[7:0].
    - If the TX FIFO is full, the byte is dropped and tx_overflow is set.
  - 1 TXWORD (W): pushes bytes [7:0], [15:8], [23:16], [31:24] in that order, all in one cycle.
    - Accepted only if free space >= 4. Otherwise none are pushed and tx_overflow is set.
  - 2 RXDATA (R): returns {23'b0, valid, head}.
    - When in_read_en is high, the read pops if the FIFO is non-empty.
    - When empty, returns 0 and does not pop.
  - 3 STATUS (R), with W1C on bits 4 and 5:
    - bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full.
    - bit4 rx_overrun, bit5 tx_overflow, bit6 tx_busy (FSM != IDLE).
    - [15:8] rx_count, [23:16] tx_count, rest 0.
  - CONTROL is the write to offset 3 when in_write_data[31] = 1:
    - bit0 rx_flush (self-clearing, 1-cycle effect).
    - bit1 tx_flush (self-clearing).
    - bit2 irq_en (held).
    - W1C of the STATUS flags applies only when bit31 = 0.
  - Reading TXDATA or TXWORD returns 0. Writes to RXDATA are ignored.
- TX FSM:
  - IDLE -> LOAD: when the TX FIFO is non-empty and in_tx_active=0.
  - LOAD (1 cycle): out_tx_byte <= head, pop, go to START.
  - START: out_tx_start=1 for exactly one cycle, go to WAIT.
  - WAIT -> IDLE: on in_tx_done.
  - Minimum byte-to-start latency from an IDLE push is 2 cycles.
- RX path:
  - in_rx_valid pushes in_rx_byte.
  - If the FIFO is full and there is no same-cycle pop, the byte is dropped and rx_overrun is set.
- Simultaneous events:
  - Push and pop in the same cycle on a full FIFO: both take effect, count unchanged.
  - Push and pop in the same cycle on an empty FIFO: the push takes effect and the pop is ignored.
  - Flush and push in the same cycle: flush wins, FIFO ends empty.
  - tx_flush during WAIT does not abort the byte already in flight.
  - W1C clear and a new error in the same cycle: the flag remains set.
- FIFO pointers wrap modulo DEPTH. Counts are clog2(DEPTH)+1 bits, zero-extended into 8-bit fields.
- out_irq = irq_en & ~rx_empty, registered (1-cycle delay).

Decomposition:
- Package mmio_uart_pkg:
  - register offsets (TXDATA..STATUS)
  - STATUS bit indices
  - CONTROL bit indices
  - TX FSM state encoding (IDLE, LOAD, START, WAIT)
- Sub-module sync_fifo #(WIDTH, DEPTH), instantiated for TX (WIDTH=8) and RX (WIDTH=8).
  - Ports: push, pop, flush, din, dout (head), count, full, empty.
  - For TXWORD, the TX side needs a 4-byte multi-push. Either give sync_fifo a push_count input (0..4) or use a 4-lane write; the FIFO must support it.

Test Plan:
- Write TXDATA 0x41, 0x42; model UART with in_tx_active and a done pulse 10 cycles later -> out_tx_byte 0x41 then 0x42, exactly one out_tx_start pulse each, tx_busy=0 at the end.
- Write TXWORD 0x44332211 -> bytes 0x11, 0x22, 0x33, 0x44 transmitted in order.
  - With TX_DEPTH=4 and 1 entry occupied, the same write pushes nothing and STATUS bit5=1.
- Pulse in_rx_valid with 0x5A, then 0xA5 -> RXDATA reads 0x15A then 0x1A5, then 0x000 with no underflow.
  - With irq_en=1, out_irq rises 1 cycle after the first push and falls after the last pop.
- Fill RX (RX_DEPTH=2) and push a third byte -> dropped, bit4=1, rx_count=2.
  - Write STATUS 0x10 -> bit4 clears.
  - A simultaneous pop and push on the full FIFO keeps count=2 and sets no overrun.
- Write CONTROL 0x80000003 with both FIFOs non-empty -> both counts 0 next cycle, and the in-flight TX byte still completes.
- Assert reset_n=0 during WAIT -> asynchronously out_tx_start=0, STATUS=0x00000006, FSM IDLE; after release no byte is resent.
